// File: rtl/fdiv_recip_table_gen_pkg.sv
// Shared constants, entry layout and FSM states for the FDIV reciprocal table generator.
package fdiv_pkg;

    localparam int unsigned INITIAL_ADDR_WIDTH = 10;
    localparam int unsigned GRAD_W             = 13;
    localparam int unsigned CONST_W            = 23;
    localparam int unsigned DIV_CYCLES         = 26;
    localparam int unsigned DIVISOR_W          = 12;
    localparam int unsigned QUO_W              = 26;
    localparam int unsigned Q_W                = 25;

    typedef struct packed {
        logic [GRAD_W-1:0]  gradient;
        logic [CONST_W-1:0] constant;
    } fdiv_tbl_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StWrite,
        StDone
    } fdiv_state_e;

endpackage

// File: rtl/fdiv_recip_table_gen_if.sv
// Control handshake and table RAM write port of the reciprocal table generator.
interface fdiv_recip_table_gen_if #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned ENTRY_W = 36
);
    logic               start;
    logic               busy;
    logic               done;
    logic               table_valid;
    logic               tbl_we;
    logic [ADDR_W-1:0]  tbl_addr;
    logic [ENTRY_W-1:0] tbl_wdata;

    modport master (
        input  start,
        output busy, done, table_valid, tbl_we, tbl_addr, tbl_wdata
    );

    modport slave (
        output start,
        input  busy, done, table_valid, tbl_we, tbl_addr, tbl_wdata
    );
endinterface

// File: rtl/fdiv_recip_table_gen_div.sv
// Radix-2 restoring divider computing floor(2^35 / divisor), one quotient bit per cycle, MSB first.
module recip_div_seq
    import fdiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [QUO_W-1:0]     quotient,
    output logic                 q_valid
);

    // Dividend bits above the quotient field seed the remainder; all lower dividend bits are zero.
    localparam logic [DIVISOR_W-1:0] InitRem = DIVISOR_W'(1 << (35 - QUO_W));

    logic [DIVISOR_W-1:0] div_q;
    logic [DIVISOR_W-1:0] rem_q;
    logic [QUO_W-1:0]     quo_q;
    logic [4:0]           cnt_q;
    logic                 run_q;
    logic                 valid_q;
    logic [DIVISOR_W:0]   shifted;
    logic                 fits;

    always_comb begin
        shifted = {rem_q, 1'b0};
        fits    = shifted >= {1'b0, div_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (load) begin
                div_q <= divisor;
                rem_q <= InitRem;
                quo_q <= '0;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= fits ? DIVISOR_W'(shifted - {1'b0, div_q}) : DIVISOR_W'(shifted);
                quo_q <= {quo_q[QUO_W-2:0], fits};
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_CYCLES - 1)) begin
                    run_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;
    assign q_valid  = valid_q;

endmodule

// File: rtl/fdiv_recip_table_gen.sv
// FDIV reciprocal seed table writer: one division per breakpoint, one RAM write per entry.
// Build option: FDIV_TABLE_ROUND_EN selects round-to-nearest Q instead of truncation.
module fdiv_recip_table_gen
    import fdiv_pkg::*;
#(
    parameter int unsigned ADDR_W  = INITIAL_ADDR_WIDTH,
    parameter int unsigned ENTRY_W = GRAD_W + CONST_W
) (
    input logic                  clk,
    input logic                  rst_n,
    fdiv_recip_table_gen_if.master bus
);

    localparam int unsigned Entries = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LastK = Entries[ADDR_W:0];
    localparam logic [ADDR_W:0] KOne  = {{ADDR_W{1'b0}}, 1'b1};

    fdiv_state_e          state_q;
    logic [ADDR_W:0]      k_q;
    logic [ADDR_W:0]      k_next;
    logic [4:0]           div_cnt_q;
    logic [Q_W-1:0]       prev_q;
    logic [Q_W-1:0]       q_cur;
    logic [Q_W-1:0]       diff;
    logic [Q_W-1:0]       grad_sum;
    logic                 div_load;
    logic                 div_valid;
    logic [DIVISOR_W-1:0] divisor;
    logic [QUO_W-1:0]     q26;
    fdiv_tbl_entry_t      entry;

    logic                 busy_q;
    logic                 done_q;
    logic                 valid_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [ENTRY_W-1:0]   wdata_q;

    always_comb begin
        k_next   = (state_q == StIdle) ? '0 : k_q + KOne;
        div_load = ((state_q == StIdle) && bus.start) || ((state_q == StWrite) && (k_q != LastK));
        divisor  = DIVISOR_W'(Entries + 32'(k_next));
`ifdef FDIV_TABLE_ROUND_EN
        q_cur    = Q_W'((q26 + QUO_W'(1)) >> 1);
`else
        q_cur    = Q_W'(q26 >> 1);
`endif
        // Slope uses unsaturated Q; only Q(0) = 2^24 exceeds the constant field.
        diff           = prev_q - q_cur;
        grad_sum       = diff + Q_W'(4);
        entry.gradient = GRAD_W'(grad_sum >> 3);
        entry.constant = (prev_q > Q_W'(24'hFFFFFF)) ? '1 : CONST_W'(prev_q);
    end

    recip_div_seq u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .divisor  (divisor),
        .quotient (q26),
        .q_valid  (div_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            div_cnt_q <= '0;
            prev_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q   <= StDiv;
                        k_q       <= '0;
                        div_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b0;
                    end
                end
                StDiv: begin
                    div_cnt_q <= div_cnt_q + 5'd1;
                    if (div_cnt_q == 5'(DIV_CYCLES - 1)) begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    // k = 0 only primes prev_q; entry k-1 needs both Q(k-1) and Q(k).
                    if ((k_q != '0) && div_valid) begin
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_W'(k_q - KOne);
                        wdata_q <= ENTRY_W'(entry);
                    end
                    prev_q    <= q_cur;
                    div_cnt_q <= '0;
                    if (k_q == LastK) begin
                        state_q <= StDone;
                    end else begin
                        k_q     <= k_next;
                        state_q <= StDiv;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.table_valid = valid_q;
    assign bus.tbl_we      = we_q;
    assign bus.tbl_addr    = addr_q;
    assign bus.tbl_wdata   = wdata_q;

endmodule

// File: tb/tb_fdiv_recip_table_gen.sv
// Directed bench for fdiv_recip_table_gen: timing, hand-computed entries, full-table model, reset.
module tb_fdiv_recip_table_gen;

    logic clk;
    logic rst_n;

    fdiv_recip_table_gen_if #(.ADDR_W(10), .ENTRY_W(36)) bus ();

    fdiv_recip_table_gen #(.ADDR_W(10), .ENTRY_W(36)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [24:0] model_q(input int k);
        logic [63:0] q26;
        q26 = (64'd1 << 35) / 64'(1024 + k);
`ifdef FDIV_TABLE_ROUND_EN
        return 25'((q26 + 64'd1) >> 1);
`else
        return 25'(q26 >> 1);
`endif
    endfunction

    function automatic logic [35:0] model_entry(input int i);
        logic [24:0] qa;
        logic [24:0] qb;
        logic [24:0] d;
        logic [22:0] c;
        qa = model_q(i);
        qb = model_q(i + 1);
        d  = qa - qb + 25'd4;
        c  = (qa > 25'hFFFFFF) ? 23'h7FFFFF : qa[22:0];
        return {13'(d >> 3), c};
    endfunction

    // Write capture
    logic [35:0] mem   [1024];
    logic [35:0] first [1024];
    bit          written [1024];
    int wr_cnt, dup_err, order_err, spacing_err, last_addr, last_cyc;
    int cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.tbl_we) begin
            int idx;
            idx = int'(bus.tbl_addr);
            if (written[idx]) dup_err++;
            if (wr_cnt > 0 && idx <= last_addr) order_err++;
            if (wr_cnt > 0 && (cyc - last_cyc) != 27) spacing_err++;
            written[idx] = 1'b1;
            mem[idx]     = bus.tbl_wdata;
            last_addr    = idx;
            last_cyc     = cyc;
            wr_cnt++;
        end
    end

    task automatic clear_capture();
        for (int i = 0; i < 1024; i++) begin
            written[i] = 1'b0;
            mem[i]     = '0;
        end
        wr_cnt = 0; dup_err = 0; order_err = 0; spacing_err = 0; last_addr = 0; last_cyc = 0;
    endtask

    // Called #1 after an edge; start is sampled at the following edge.
    task automatic launch();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_full(input string tag, input int inject_at);
        int  n;
        bit  seen;
        launch();
        check({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        check({tag, "_valid_cleared"}, 64'(bus.table_valid), 64'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30000) begin
            bus.start = (n == inject_at);
            @(posedge clk);
            #1;
            n++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check({tag, "_done_latency"}, 64'(n), 64'd27676);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_valid_at_done"}, 64'(bus.table_valid), 64'd1);
    endtask

    task automatic verify_table(input string tag);
        int bad, first_bad;
        check({tag, "_write_count"}, 64'(wr_cnt), 64'd1024);
        check({tag, "_duplicates"}, 64'(dup_err), 64'd0);
        check({tag, "_ascending"}, 64'(order_err), 64'd0);
        check({tag, "_spacing"}, 64'(spacing_err), 64'd0);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 1024; i++) begin
            if (!written[i] || mem[i] !== model_entry(i)) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_model: %0d bad entries, first at %0d got %0h expected %0h",
                     tag, bad, first_bad, mem[first_bad], model_entry(first_bad));
        end
    endtask

    typedef struct {
        int          addr;
        logic [12:0] grad;
        logic [22:0] cst;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{addr: 0,    grad: 13'd2046, cst: 23'h7FFFFF};
`ifdef FDIV_TABLE_ROUND_EN
        vecs[1] = '{addr: 1,    grad: 13'd2042, cst: 23'h7FC010};
`else
        vecs[1] = '{addr: 1,    grad: 13'd2042, cst: 23'h7FC00F};
`endif
        vecs[2] = '{addr: 1023, grad: 13'd512,  cst: 23'h001002};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        clear_capture();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_valid", 64'(bus.table_valid), 64'd0);
        check("rst_we", 64'(bus.tbl_we), 64'd0);
        check("rst_addr", 64'(bus.tbl_addr), 64'd0);
        check("rst_wdata", 64'(bus.tbl_wdata), 64'd0);

        // Reset in the middle of the k=3 division
        launch();
        repeat (27 * 3 + 10) @(posedge clk);
        #1;
        check("pre_reset_writes", 64'(wr_cnt), 64'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_capture();
        repeat (200) @(posedge clk);
        #1;
        check("post_reset_writes", 64'(wr_cnt), 64'd0);
        check("post_reset_busy", 64'(bus.busy), 64'd0);
        check("post_reset_valid", 64'(bus.table_valid), 64'd0);
        check("post_reset_done", 64'(bus.done), 64'd0);

        // Restart with a stray start near k=500
        clear_capture();
        run_full("runA", 500 * 27 + 5);
        verify_table("runA");
        for (int v = 0; v < 3; v++) begin
            check($sformatf("vec%0d_grad", vecs[v].addr), 64'(mem[vecs[v].addr][35:23]),
                  64'(vecs[v].grad));
            check($sformatf("vec%0d_const", vecs[v].addr), 64'(mem[vecs[v].addr][22:0]),
                  64'(vecs[v].cst));
        end
        for (int i = 0; i < 1024; i++) first[i] = mem[i];

        // Back-to-back: start sampled in the cycle done is high
        clear_capture();
        run_full("runB", -1);
        @(posedge clk);
        #1;
        check("runB_done_pulse", 64'(bus.done), 64'd0);
        verify_table("runB");
        begin
            int diffs;
            diffs = 0;
            for (int i = 0; i < 1024; i++) if (mem[i] !== first[i]) diffs++;
            check("runB_matches_runA", 64'(diffs), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fdiv_recip_table_gen.md
# fdiv_recip_table_gen

Sequential generator for the FDIV reciprocal seed table. It computes the 1024 piecewise-linear 1/x entries, each {gradient[12:0], constant[22:0]}, using a radix-2 restoring divider, and writes them through a RAM write port. The reciprocal stage of the FDIV pipeline reads this table, so the block is the writer side of that table and runs once after boot or on request. While it runs, `busy` is high and the FDIV pipeline must not issue.

## Interface
- `ADDR_W`, 10: table index width (entries = 2^ADDR_W)
- `ENTRY_W`, 36: entry width, {gradient 13b, constant 23b}
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous and active-low
- `start`  in  1  one-cycle request to regenerate the table
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the last entry has been written
- `table_valid`  out  1  set with `done`; cleared on an accepted `start` and on reset
- `tbl_we`  out  1  RAM write enable, one cycle per entry
- `tbl_addr`  out  ADDR_W  RAM write address
- `tbl_wdata`  out  ENTRY_W  RAM write data

## Operation
- Math: entry i covers x in [1+i/1024, 1+(i+1)/1024).
  - Q(k) = 2^34 / (1024+k), for k = 0..1024. Q is 2/x scaled by 2^23.
  - constant(i) = min(Q(i), 2^24-1)[22:0]. Only entry 0 saturates, giving 0x7FFFFF.
  - D = Q(i) − Q(i+1), computed on unsaturated Q.
  - gradient(i) = (D+4)>>3, 13 bits, maximum 2046.
- Divider: dividend 2^35, divisor d = 1024+k (12 bits, up to 2048). It produces a 26-bit raw quotient Q26 = floor(2^35/d), one bit per cycle, MSB first. Q(k) is derived from Q26 as set by the macro under Configuration.
- FSM:
  - IDLE: on `start`, go to DIV with k=0. Set `busy`, clear `table_valid`.
  - DIV: 26 cycles, one quotient bit per cycle. Then go to WRITE.
  - WRITE: 1 cycle.
    - If k≥1: `tbl_we`=1, `tbl_addr`=k−1, data built from prev_q=Q(k−1) and Q(k).
    - In all cases prev_q←Q(k).
    - If k==1024: go to DONE. Otherwise k←k+1 and go to DIV.
  - DONE: 1 cycle. `done`=1, `table_valid`←1, `busy`←0. Go to IDLE.
- `start` while `busy` is ignored. `start` in the DONE cycle is ignored.
- Reset at any cycle, including mid-division or in WRITE:
  - next cycle is IDLE, k=0, `table_valid`=0;
  - no further `tbl_we`; partially written contents are not valid.
- Only Q(k) and prev_q are stored between entries. There is no table buffering.

## Timing
- Reset values: `busy`, `done`, `table_valid`, `tbl_we` = 0; `tbl_addr`, `tbl_wdata` = 0.
- `busy` rises 1 cycle after `start` is sampled.
- Each k takes 27 cycles (26 DIV + 1 WRITE). There are 1025 divisions.
- `done` is asserted 27676 cycles after the `start` edge (DONE state included).
- Writes are 27 cycles apart. Addresses run strictly ascending 0..1023, and each address is written exactly once.
- `tbl_addr`/`tbl_wdata` are registered and valid only while `tbl_we`=1. Otherwise they hold their last value.

## Configuration
- `FDIV_TABLE_ROUND_EN` defined: Q = (Q26+1)>>1, round-to-nearest.
- `FDIV_TABLE_ROUND_EN` undefined: Q = Q26>>1, truncation.
- The gradient rounding (+4) is always present. Cycle timing is identical in both builds.

## Structure
- Package `fdiv_pkg`:
  - constants `INITIAL_ADDR_WIDTH`=10, `GRAD_W`=13, `CONST_W`=23, `DIV_CYCLES`=26;
  - `fdiv_tbl_entry_t` packed struct {gradient, constant};
  - FSM state enum.
- Sub-module `recip_div_seq`: restoring divider with `load`, 12-bit divisor, 26-bit quotient and a `q_valid` pulse. The top level holds the FSM, the index counter, prev_q and the entry arithmetic.

## Test plan
- Reset then idle 100 cycles, then expect all outputs 0. Send `start` and expect `busy` at the next cycle, and `done` exactly 27676 cycles after `start`.
- Round build: expect entry 0 = {2046, 0x7FFFFF}, entry 1 constant = 0x7FC010, and entry 1023 = {512, 0x001002}.
- Truncate build: expect entry 1 constant = 0x7FC00F, entry 0 gradient 2046, entry 1023 unchanged.
- Full table compared against a software model using the same formulas: all 1024 entries exact, 1024 writes total, addresses ascending, no duplicates.
- `start` pulsed mid-run (k≈500): ignored, with no timing change. Then `rst_n`=0 for one cycle mid-division: `tbl_we` stays 0 afterwards, `busy`=0, `table_valid`=0. A restart regenerates the full table correctly.
- Two back-to-back runs: `table_valid` clears on the second `start`, and the second run's data matches the first.
